// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the five-stage RV64 pipeline.
// Control-word bit positions and pipeline-wide widths.
package riscv_pipe_pkg;

    localparam int XLEN      = 64;
    localparam int REG_IDX_W = 5;
    localparam int CTRL_W    = 9;

    localparam int CTRL_ALUSRC   = 8;
    localparam int CTRL_MEMTOREG = 7;
    localparam int CTRL_REGWRITE = 6;
    localparam int CTRL_MEMREAD  = 5;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_BRANCH   = 3;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 9'b0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the EX slot and the decode slot.
// Purely combinational; rs2 is compared for every format.
module load_use_detect
    import riscv_pipe_pkg::*;
(
    input  logic                 ex_valid,
    input  logic                 ex_memread,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    output logic                 hz
);

    logic w_ld_live;
    logic w_match;

    assign w_ld_live = ex_valid & ex_memread & (ex_rd != '0);
    assign w_match   = (ex_rd == id_rs1) | (ex_rd == id_rs2);
    assign hz        = w_ld_live & id_valid & w_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion.
// Priority per edge: hold, flush, load-use stall, normal advance.
module id_ex_stage #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 9,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rd1,
    input  logic [XLEN-1:0]   id_rd2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [3:0]        id_funct,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              hold,
    input  logic              flush,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rd1,
    output logic [XLEN-1:0]   ex_rd2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [3:0]        ex_funct,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              load_use_stall,
    output logic [CNT_W-1:0]  bubble_count
);

    import riscv_pipe_pkg::*;

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rd1;
    logic [XLEN-1:0]   r_rd2;
    logic [XLEN-1:0]   r_imm;
    logic [3:0]        r_funct;
    logic [CTRL_W-1:0] r_ctrl;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [4:0]        r_rd;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_hz;
    logic              w_stall;
    logic              w_bubble;
    logic              w_cnt_sat;

    load_use_detect u_hz (
        .ex_valid   (r_valid),
        .ex_memread (r_ctrl[CTRL_MEMREAD]),
        .ex_rd      (r_rd),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .hz         (w_hz)
    );

    // Flush and hold both mask the stall; a redirect makes the hazard moot.
    assign w_stall   = w_hz & ~flush & ~hold;
    assign w_bubble  = flush | w_stall;
    assign w_cnt_sat = &r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_funct <= '0;
            r_ctrl  <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
        end else if (!hold) begin
            r_pc    <= id_pc;
            r_rd1   <= id_rd1;
            r_rd2   <= id_rd2;
            r_imm   <= id_imm;
            r_funct <= id_funct;
            r_rs1   <= id_rs1;
            r_rs2   <= id_rs2;
            if (w_bubble) begin
                r_valid <= 1'b0;
                r_ctrl  <= CTRL_W'(CTRL_BUBBLE);
                r_rd    <= '0;
            end else begin
                r_valid <= id_valid;
                r_ctrl  <= id_valid ? id_ctrl : CTRL_W'(CTRL_BUBBLE);
                r_rd    <= id_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_stall && !w_cnt_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign ex_valid       = r_valid;
    assign ex_pc          = r_pc;
    assign ex_rd1         = r_rd1;
    assign ex_rd2         = r_rd2;
    assign ex_imm         = r_imm;
    assign ex_funct       = r_funct;
    assign ex_ctrl        = r_ctrl;
    assign ex_rs1         = r_rs1;
    assign ex_rs2         = r_rs2;
    assign ex_rd          = r_rd;
    assign load_use_stall = w_stall;
    assign pc_write       = ~hold & ~w_stall;
    assign if_id_write    = ~hold & ~w_stall;
    assign bubble_count   = r_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes model results,
// a negedge monitor pops and compares against the DUT.
module tb_id_ex_stage;

    localparam int XLEN   = 64;
    localparam int CTRL_W = 9;
    localparam int CNT_W  = 4;
    localparam int unsigned CMAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc, id_rd1, id_rd2, id_imm;
    logic [3:0]        id_funct;
    logic [CTRL_W-1:0] id_ctrl;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic              hold, flush;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [3:0]        ex_funct;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [4:0]        ex_rs1, ex_rs2, ex_rd;
    logic              pc_write, if_id_write, load_use_stall;
    logic [CNT_W-1:0]  bubble_count;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .id_funct(id_funct), .id_ctrl(id_ctrl),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .hold(hold), .flush(flush), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm(ex_imm), .ex_funct(ex_funct), .ex_ctrl(ex_ctrl),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .load_use_stall(load_use_stall), .bubble_count(bubble_count)
    );

    typedef struct {
        logic        valid;
        logic [63:0] pc, rd1, rd2, imm;
        logic [3:0]  funct;
        logic [8:0]  ctrl;
        logic [4:0]  rs1, rs2, rd;
        logic        hold, flush;
    } stim_t;

    typedef struct {
        logic        valid;
        logic [63:0] pc, rd1, rd2, imm;
        logic [3:0]  funct;
        logic [8:0]  ctrl;
        logic [4:0]  rs1, rs2, rd;
    } slot_t;

    typedef struct {
        slot_t       ex;
        int unsigned cnt;
        logic        stall, pcw;
    } exp_t;

    exp_t        q[$];
    slot_t       m_ex;
    int unsigned m_cnt;
    stim_t       m_prev;
    int          n_cmp = 0;
    int          n_bad = 0;

    localparam logic [8:0] LD  = 9'h1E0;
    localparam logic [8:0] ADD = 9'h042;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // An instruction must wait if the load in EX writes a register it reads.
    function automatic bit needs_wait(slot_t e, stim_t s);
        return e.valid && e.ctrl[5] && e.rd != 0 && s.valid &&
               (e.rd == s.rs1 || e.rd == s.rs2);
    endfunction

    function automatic stim_t mk(bit v, logic [8:0] c, int r1, int r2,
                                 int d, bit h, bit f);
        stim_t s;
        s.valid = v;
        s.pc    = {$urandom, $urandom};
        s.rd1   = {$urandom, $urandom};
        s.rd2   = {$urandom, $urandom};
        s.imm   = {$urandom, $urandom};
        s.funct = 4'($urandom);
        s.ctrl  = c;
        s.rs1   = 5'(r1);
        s.rs2   = 5'(r2);
        s.rd    = 5'(d);
        s.hold  = h;
        s.flush = f;
        return s;
    endfunction

    function automatic stim_t rnd();
        logic [8:0] c;
        c = 9'($urandom) & 9'h1DB;
        if ($urandom_range(0, 9) < 4) c[5] = 1'b1;
        return mk($urandom_range(0, 7) != 0, c,
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0);
    endfunction

    task automatic model_step();
        slot_t n;
        bit    st;
        st = needs_wait(m_ex, m_prev) && !m_prev.flush && !m_prev.hold;
        if (m_prev.hold) return;
        n.pc    = m_prev.pc;
        n.rd1   = m_prev.rd1;
        n.rd2   = m_prev.rd2;
        n.imm   = m_prev.imm;
        n.funct = m_prev.funct;
        n.rs1   = m_prev.rs1;
        n.rs2   = m_prev.rs2;
        if (m_prev.flush || st) begin
            n.valid = 1'b0;
            n.ctrl  = 9'h0;
            n.rd    = 5'd0;
            if (st && m_cnt < CMAX) m_cnt = m_cnt + 1;
        end else begin
            n.valid = m_prev.valid;
            n.ctrl  = m_prev.valid ? m_prev.ctrl : 9'h0;
            n.rd    = m_prev.rd;
        end
        m_ex = n;
    endtask

    task automatic drive(stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        model_step();
        id_valid = s.valid; id_pc = s.pc; id_rd1 = s.rd1;
        id_rd2 = s.rd2; id_imm = s.imm; id_funct = s.funct;
        id_ctrl = s.ctrl; id_rs1 = s.rs1; id_rs2 = s.rs2;
        id_rd = s.rd; hold = s.hold; flush = s.flush;
        m_prev = s;
        e.ex    = m_ex;
        e.cnt   = m_cnt;
        e.stall = needs_wait(m_ex, s) && !s.flush && !s.hold;
        e.pcw   = !s.hold && !e.stall;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ex_valid", 64'(ex_valid), 64'(e.ex.valid));
                chk("ex_ctrl", 64'(ex_ctrl), 64'(e.ex.ctrl));
                chk("ex_rd", 64'(ex_rd), 64'(e.ex.rd));
                chk("bubble_count", 64'(bubble_count), 64'(e.cnt));
                chk("load_use_stall", 64'(load_use_stall), 64'(e.stall));
                chk("pc_write", 64'(pc_write), 64'(e.pcw));
                chk("if_id_write", 64'(if_id_write), 64'(e.pcw));
                if (e.ex.valid) begin
                    chk("ex_pc", ex_pc, e.ex.pc);
                    chk("ex_rd1", ex_rd1, e.ex.rd1);
                    chk("ex_rd2", ex_rd2, e.ex.rd2);
                    chk("ex_imm", ex_imm, e.ex.imm);
                    chk("ex_funct", 64'(ex_funct), 64'(e.ex.funct));
                    chk("ex_rs1", 64'(ex_rs1), 64'(e.ex.rs1));
                    chk("ex_rs2", 64'(ex_rs2), 64'(e.ex.rs2));
                end
            end
        end
    end

    initial begin : driver
        stim_t s;
        reset_n = 1'b0;
        id_valid = 0; id_pc = 0; id_rd1 = 0; id_rd2 = 0; id_imm = 0;
        id_funct = 0; id_ctrl = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        hold = 0; flush = 0;
        m_ex = '{default: '0};
        m_prev = '{default: '0};
        m_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ex_valid", 64'(ex_valid), 64'd0);
        chk("rst_count", 64'(bubble_count), 64'd0);
        chk("rst_pc_write", 64'(pc_write), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;

        s = mk(1, ADD, 1, 2, 3, 0, 0);
        s.pc = 64'h1000; s.rd1 = 64'd5; s.rd2 = 64'd7;
        drive(s);
        drive(mk(1, LD, 1, 0, 5, 0, 0));
        #1;
        chk("pass_pc", ex_pc, 64'h1000);
        chk("pass_rd1", ex_rd1, 64'd5);
        chk("pass_rd2", ex_rd2, 64'd7);
        chk("pass_ctrl", 64'(ex_ctrl), 64'h042);
        chk("pass_rd", 64'(ex_rd), 64'd3);
        chk("pass_pc_write", 64'(pc_write), 64'd1);
        s = mk(1, ADD, 5, 6, 7, 0, 0);
        drive(s);
        #1;
        chk("lu_stall", 64'(load_use_stall), 64'd1);
        chk("lu_pc_write", 64'(pc_write), 64'd0);
        chk("lu_if_id_write", 64'(if_id_write), 64'd0);
        drive(s);
        #1;
        chk("lu_bubble_ctrl", 64'(ex_ctrl), 64'd0);
        chk("lu_bubble_valid", 64'(ex_valid), 64'd0);
        chk("lu_count", 64'(bubble_count), 64'd1);
        chk("lu_no_restall", 64'(load_use_stall), 64'd0);
        drive(mk(0, 9'h0, 0, 0, 0, 0, 0));
        #1;
        chk("lu_adv_rs1", 64'(ex_rs1), 64'd5);
        chk("lu_adv_ctrl", 64'(ex_ctrl), 64'h042);

        drive(mk(1, LD, 1, 2, 0, 0, 0));
        drive(mk(1, ADD, 0, 0, 4, 0, 0));
        #1;
        chk("x0_stall", 64'(load_use_stall), 64'd0);
        drive(mk(1, LD, 1, 2, 6, 0, 0));
        drive(mk(1, ADD, 5, 7, 4, 0, 0));
        #1;
        chk("nomatch_stall", 64'(load_use_stall), 64'd0);

        drive(mk(1, LD, 1, 2, 5, 0, 0));
        drive(mk(1, ADD, 5, 0, 4, 0, 1));
        #1;
        chk("flush_stall", 64'(load_use_stall), 64'd0);
        chk("flush_pc_write", 64'(pc_write), 64'd1);
        drive(mk(0, 9'h0, 0, 0, 0, 0, 0));
        #1;
        chk("flush_valid", 64'(ex_valid), 64'd0);
        chk("flush_count", 64'(bubble_count), 64'd1);

        drive(mk(1, LD, 1, 2, 5, 0, 0));
        s = mk(1, ADD, 5, 0, 4, 1, 0);
        drive(s);
        #1;
        chk("hold_stall", 64'(load_use_stall), 64'd0);
        chk("hold_pc_write", 64'(pc_write), 64'd0);
        drive(s);
        #1;
        chk("hold_rd", 64'(ex_rd), 64'd5);
        chk("hold_ctrl", 64'(ex_ctrl), 64'(LD));
        s.hold = 1'b0;
        drive(s);
        #1;
        chk("hold_release_stall", 64'(load_use_stall), 64'd1);

        for (int i = 0; i < 3000; i++) drive(rnd());
        drive(mk(1, ADD, 0, 0, 1, 0, 0));
        #1;
        chk("sat_count", 64'(bubble_count), 64'(CMAX));

        drive(mk(1, ADD, 0, 0, 9, 0, 0));
        @(posedge clk);
        #3;
        chk("pre_rst_valid", 64'(ex_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 64'(ex_valid), 64'd0);
        chk("arst_ctrl", 64'(ex_ctrl), 64'd0);
        chk("arst_rd", 64'(ex_rd), 64'd0);
        chk("arst_pc", ex_pc, 64'd0);
        chk("arst_rd1", ex_rd1, 64'd0);
        chk("arst_rs1", 64'(ex_rs1), 64'd0);
        chk("arst_count", 64'(bubble_count), 64'd0);
        chk("arst_pc_write", 64'(pc_write), 64'd1);
        chk("arst_if_id_write", 64'(if_id_write), 64'd1);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
